// File: rtl/poly_to_int_reduce.sv
// Carry-propagates redundant squaring-core coefficients into one integer, then reduces it
// modulo MODULUS by repeated trial subtraction. POLY_TO_INT_SUB_CAP_EN bounds the subtract count.
module poly_to_int_reduce #(
    parameter int WORD_BITS       = 35,
    parameter int NUM_WORDS       = 30,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = (WORD_BITS*NUM_WORDS)'(
        1024'hc7970ceedcc3b075_4490201a7aa613cd_73911081c790f5f1_a8726f463550bb5b_7ff0db8e1ea1189e_c72f93d1650011bd_721aeeacc2acde32_a04107f0648c2813_a31f5b0b7765ff8b_44b4b6ffc93384b6_46eb09c7cf5e8592_d40ea33c80039f35_b4f14a04b51f7bfd_781be4d1673164ba_8eb991c2c4d730bb_be35f592bdef524b),
    parameter int REDUN_WORD_BITS = 1,
    parameter int I_WORD          = NUM_WORDS + 1,
    parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int MAX_SUB         = 3
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_val,
    output logic                                 o_rdy,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]     i_dat,
    output logic                                 o_val,
    input  logic                                 i_rdy,
    output logic [WORD_BITS*NUM_WORDS-1:0]       o_int,
    output logic                                 o_err
);

    localparam int MW    = WORD_BITS * NUM_WORDS;
    localparam int ACC_W = I_WORD * WORD_BITS + REDUN_WORD_BITS + 1;
    localparam int CR_W  = ACC_W - I_WORD * WORD_BITS;
    localparam int S_W   = ((COEF_BITS > CR_W) ? COEF_BITS : CR_W) + 1;
    localparam int SW    = ((ACC_W > MW) ? ACC_W : MW) + 1;
    localparam int KW    = (I_WORD > 1) ? $clog2(I_WORD) : 1;
    localparam int CW    = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

`ifdef POLY_TO_INT_SUB_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CARRY, SUB, DONE} state_t;

    state_t                          state, state_nxt;
    logic                            live;
    logic [I_WORD-1:0][COEF_BITS-1:0] coef;
    logic [KW-1:0]                   k;
    logic [CR_W-1:0]                 carry, carry_nxt;
    logic [ACC_W-1:0]                acc;
    logic [CW-1:0]                   sub_cnt;
    logic                            err;
    logic [S_W-1:0]                  s;
    logic [SW-1:0]                   acc_x, diff;
    logic                            borrow, cap_hit, last_k, accept;

    assign s         = S_W'(coef[k]) + S_W'(carry);
    assign carry_nxt = CR_W'(s >> WORD_BITS);
    assign last_k    = (k == KW'(I_WORD - 1));
    assign accept    = i_val && o_rdy;

    // One extra bit above the wider operand makes its MSB the borrow flag.
    assign acc_x   = SW'(acc);
    assign diff    = acc_x - SW'(MODULUS);
    assign borrow  = diff[SW-1];
    assign cap_hit = CAP_EN && (sub_cnt == CW'(MAX_SUB));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CARRY;
            CARRY:   if (last_k) state_nxt = SUB;
            SUB:     if (borrow || cap_hit) state_nxt = DONE;
            DONE:    if (i_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            live    <= 1'b0;
            coef    <= '0;
            k       <= '0;
            carry   <= '0;
            acc     <= '0;
            sub_cnt <= '0;
            err     <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    coef    <= i_dat;
                    k       <= '0;
                    carry   <= '0;
                    sub_cnt <= '0;
                    err     <= 1'b0;
                end
                CARRY: begin
                    acc[int'(k)*WORD_BITS +: WORD_BITS] <= s[WORD_BITS-1:0];
                    carry <= carry_nxt;
                    k     <= k + 1'b1;
                    // Final carry lands in the headroom above the top word.
                    if (last_k) acc[ACC_W-1 -: CR_W] <= carry_nxt;
                end
                SUB: begin
                    if (!borrow && !cap_hit) begin
                        acc     <= diff[ACC_W-1:0];
                        sub_cnt <= sub_cnt + 1'b1;
                    end else if (!borrow) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rdy = (state == IDLE) && live;
    assign o_val = (state == DONE);
    assign o_int = acc_x[MW-1:0];
    assign o_err = CAP_EN & err;

endmodule

// File: tb/tb_poly_to_int_reduce.sv
// Randomized bench for poly_to_int_reduce against an arithmetic model (X mod M, latency from q).
// Honors POLY_TO_INT_SUB_CAP_EN to match the DUT build.
module tb_poly_to_int_reduce;

    localparam int WB = 4, NW = 2, RB = 1, IW = 3, CB = 5, MODV = 200, MS = 3;

    typedef struct {
        int t;
        int lat;
        int val;
        bit err;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst, i_val, i_rdy, o_rdy, o_val, o_err;
    logic [IW-1:0][CB-1:0] i_dat;
    logic [WB*NW-1:0]   o_int;

    int   total = 0, bad = 0, cyc = 0;
    exp_t exp_q[$];
    bit   seen = 0;

    poly_to_int_reduce #(
        .WORD_BITS(WB), .NUM_WORDS(NW), .MODULUS(8'd200), .REDUN_WORD_BITS(RB),
        .I_WORD(IW), .COEF_BITS(CB), .MAX_SUB(MS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat(i_dat),
        .o_val(o_val), .i_rdy(i_rdy), .o_int(o_int), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // X is reduced by subtracting M q times (or at most MS times when capped).
    function automatic void model(input int x, output int val, output bit err, output int lat);
        int q, n;
        q = x / MODV;
        n = q;
`ifdef POLY_TO_INT_SUB_CAP_EN
        if (n > MS) n = MS;
        err = (q > MS);
`else
        err = 1'b0;
`endif
        val = (x - n * MODV) % 256;
        lat = IW + n + 2;
    endfunction

    function automatic int value_of(input logic [CB-1:0] c2, c1, c0);
        return int'(c0) + int'(c1) * 16 + int'(c2) * 256;
    endfunction

    // Single compare process: every cycle o_val is high the outputs must match the head entry.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            seen = 0;
        end else if (o_val) begin
            if (exp_q.size() == 0) begin
                chk("spurious_o_val", o_val, 0);
            end else begin
                if (!seen) chk("latency", cyc - exp_q[0].t, exp_q[0].lat);
                seen = 1;
                chk("o_int", o_int, exp_q[0].val);
                chk("o_err", o_err, exp_q[0].err);
                if (i_rdy) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic run_txn(input logic [CB-1:0] c2, c1, c0, input int hold);
        exp_t e;
        int   n;
        bit   ok;
        @(posedge clk); #1;
        i_dat = {c2, c1, c0};
        i_val = 1'b1;
        n = 0; ok = 0;
        while (n < 100) begin
            @(negedge clk);
            if (o_rdy) begin ok = 1; break; end
            n++;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            i_val = 1'b0;
            return;
        end
        e.t = cyc;
        model(value_of(c2, c1, c0), e.val, e.err, e.lat);
        exp_q.push_back(e);
        @(posedge clk); #1 i_val = 1'b0;
        n = 0; ok = 0;
        while (n < 200) begin
            @(negedge clk);
            if (o_val) begin ok = 1; break; end
            n++;
        end
        if (!ok) begin
            chk("o_val_timeout", 0, 1);
            exp_q.delete();
            return;
        end
        // Held result with junk offered on the input side.
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            i_val = 1'b1;
            i_dat = (IW*CB)'($urandom);
            @(negedge clk);
            chk("bp_o_rdy", o_rdy, 0);
            chk("bp_o_val", o_val, 1);
        end
        @(posedge clk); #1 i_rdy = 1'b1;
        @(posedge clk); #1;
        i_rdy = 1'b0;
        i_val = 1'b0;
        @(negedge clk);
        chk("release_o_val", o_val, 0);
        chk("release_o_rdy", o_rdy, 1);
    endtask

    task automatic reset_mid_txn();
        @(posedge clk); #1;
        i_dat = {5'd31, 5'd31, 5'd31};
        i_val = 1'b1;
        @(negedge clk);
        chk("rst_pre_o_rdy", o_rdy, 1);
        @(posedge clk); #1 i_val = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_o_val", o_val, 0);
        chk("rst_o_rdy", o_rdy, 0);
        chk("rst_o_int", o_int, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rel_o_rdy", o_rdy, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_no_o_val", o_val, 0);
        end
    endtask

    initial begin
        int  v, l;
        bit  er;
        rst = 1'b1; i_val = 1'b0; i_rdy = 1'b0; i_dat = '0;

        // Hand-computed anchors for the model.
        model(0, v, er, l);
        chk("model0_val", v, 0); chk("model0_lat", l, 5);
        model(value_of(5'd0, 5'd17, 5'd20), v, er, l);
        chk("model292_val", v, 92); chk("model292_lat", l, 6);
        model(value_of(5'd0, 5'd12, 5'd8), v, er, l);
        chk("model200_val", v, 0); chk("model200_lat", l, 6);
        model(value_of(5'd31, 5'd31, 5'd31), v, er, l);
`ifdef POLY_TO_INT_SUB_CAP_EN
        chk("model8463_val", v, 183); chk("model8463_err", er, 1); chk("model8463_lat", l, 8);
`else
        chk("model8463_val", v, 63); chk("model8463_err", er, 0); chk("model8463_lat", l, 47);
`endif

        @(negedge clk);
        chk("reset_o_val", o_val, 0);
        chk("reset_o_rdy", o_rdy, 0);
        chk("reset_o_int", o_int, 0);
        chk("reset_o_err", o_err, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_o_rdy", o_rdy, 1);

        run_txn(5'd0, 5'd0, 5'd0, 0);
        run_txn(5'd0, 5'd17, 5'd20, 1);
        run_txn(5'd0, 5'd12, 5'd8, 0);
        run_txn(5'd31, 5'd31, 5'd31, 5);
        reset_mid_txn();

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) run_txn(5'd31, 5'(i), 5'd31, $urandom_range(0, 3));
            else run_txn(5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 3));
        end
        run_txn(5'd0, 5'd0, 5'd0, 2);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
